bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 tb/tb_bin2bcd_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encoding, digit width and the counter-width helper.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/busy/done handshake; feeds the seven-segment display decoders.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for start; latches |din| and sign on accept
//   ST_SHIFT | one correct+shift step per clock, WIDTH steps in total
//   ST_DONE  | bcd/neg freshly registered; done pulses for one cycle
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        din,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    neg
);

  localparam int SW = BCD_W * DIGITS;
  localparam int CW = cnt_width(WIDTH);

  state_t              state, state_nx;
  logic [WIDTH-1:0]    mag;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       adj;
  logic [CW-1:0]       cnt;
  logic                neg_i;

  logic                din_neg;
  logic [WIDTH-1:0]    din_mag;
  logic [SW+WIDTH-1:0] shifted;
  logic                last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch[g*BCD_W +: BCD_W]),
      .q (adj[g*BCD_W +: BCD_W])
    );
  end

  // Magnitude is taken in WIDTH bits: the most-negative value maps to itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    din_neg    = (SIGNED != 0) && din[WIDTH-1];
    din_mag    = din_neg ? (~din + 1'b1) : din;
    shifted    = {adj, mag} << 1;
    last_shift = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      neg     <= 1'b0;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      neg_i   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            mag     <= din_mag;
            neg_i   <= din_neg;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          {scratch, mag} <= shifted;
          cnt            <= cnt + 1'b1;
          // Outputs only ever take the completed result.
          if (last_shift) begin
            bcd <= shifted[SW+WIDTH-1:WIDTH];
            neg <= neg_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: signed and unsigned builds
// driven side by side, checked against hand-computed BCD values.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  din = 8'h00;

  logic        busy_s, done_s, neg_s;
  logic [11:0] bcd_s;
  logic        busy_u, done_u, neg_u;
  logic [11:0] bcd_u;

  int n_checks = 0;
  int n_errors = 0;

  // din, signed bcd, signed neg, unsigned bcd
  logic [7:0]  tv     [8] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h0A, 8'h9C, 8'h63, 8'hC8};
  logic [11:0] ts_bcd [8] = '{12'h000, 12'h127, 12'h128, 12'h001, 12'h010, 12'h100, 12'h099, 12'h056};
  logic        ts_neg [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [11:0] tu_bcd [8] = '{12'h000, 12'h127, 12'h128, 12'h255, 12'h010, 12'h156, 12'h099, 12'h200};

  int q_idx [$];
  int q_cyc [$];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy_s),
    .done  (done_s),
    .bcd   (bcd_s),
    .neg   (neg_s)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy_u),
    .done  (done_u),
    .bcd   (bcd_u),
    .neg   (neg_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion of tv[idx]; optional extra start pulses at cycles 3 and 8.
  task automatic run_conv(input int idx, input bit glitch);
    logic [11:0] prev_s, prev_u, got_s, got_u;
    logic        got_neg_s, got_neg_u;
    int          k, bcnt, dcnt, dlat;
    bit          hold_ok, fin;
    string       t;
    t = $sformatf("%02h%s", tv[idx], glitch ? "_glitch" : "");
    got_s = '0; got_u = '0; got_neg_s = 1'b0; got_neg_u = 1'b1;
    bcnt = 0; dcnt = 0; dlat = -1; hold_ok = 1'b1; fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    din   = tv[idx];
    prev_s = bcd_s;
    prev_u = bcd_u;
    @(posedge clk); #1;
    start = 1'b0;
    din   = 8'h55;
    k = 0;
    while (k < 40 && !fin) begin
      if (!busy_s) begin
        fin = 1'b1;
      end else begin
        bcnt++;
        if (done_s) begin
          dcnt++;
          if (dlat < 0) dlat = k;
          got_s = bcd_s; got_neg_s = neg_s;
          got_u = bcd_u; got_neg_u = neg_u;
        end else if (bcd_s !== prev_s || bcd_u !== prev_u) begin
          hold_ok = 1'b0;
        end
        if (glitch && (k == 3 || k == 8)) begin
          start = 1'b1;
          din   = 8'h3C;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    check({"timeout_", t}, {31'd0, fin}, 32'd1);
    check({"busy_cycles_", t}, bcnt, 9);
    check({"done_count_", t}, dcnt, 1);
    check({"done_latency_", t}, dlat, 8);
    check({"bcd_s_", t}, {20'd0, got_s}, {20'd0, ts_bcd[idx]});
    check({"neg_s_", t}, {31'd0, got_neg_s}, {31'd0, ts_neg[idx]});
    check({"bcd_u_", t}, {20'd0, got_u}, {20'd0, tu_bcd[idx]});
    check({"neg_u_", t}, {31'd0, got_neg_u}, 32'd0);
    check({"hold_", t}, {31'd0, hold_ok}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check({"idle_after_", t}, {30'd0, busy_s, done_s}, 32'd0);
  endtask

  initial begin
    int  idx, acc_n;
    bit  seen_done;

    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy_s}, 32'd0);
    check("reset_done", {31'd0, done_s}, 32'd0);
    check("reset_bcd",  {20'd0, bcd_s}, 32'd0);
    check("reset_neg",  {31'd0, neg_s}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_conv(0, 1'b0);
    run_conv(1, 1'b0);
    run_conv(2, 1'b0);
    run_conv(3, 1'b0);
    run_conv(4, 1'b0);
    run_conv(7, 1'b0);
    run_conv(6, 1'b1);

    // start held high: accept whenever the converter is idle
    start = 1'b1;
    for (int c = 0; c < 39; c++) begin
      @(negedge clk);
      din = tv[c % 8];
      if (!busy_s) begin
        q_idx.push_back(c % 8);
        q_cyc.push_back(c);
      end
      @(posedge clk); #1;
      if (done_s) begin
        if (q_idx.size() > 0) begin
          idx = q_idx.pop_front();
          check($sformatf("b2b_bcd_s_%02h", tv[idx]), {20'd0, bcd_s}, {20'd0, ts_bcd[idx]});
          check($sformatf("b2b_neg_s_%02h", tv[idx]), {31'd0, neg_s}, {31'd0, ts_neg[idx]});
          check($sformatf("b2b_bcd_u_%02h", tv[idx]), {20'd0, bcd_u}, {20'd0, tu_bcd[idx]});
        end else begin
          check("b2b_spurious_done", 32'd1, 32'd0);
        end
      end
    end
    start = 1'b0;
    acc_n = q_cyc.size();
    check("b2b_accepts", acc_n, 4);
    check("b2b_pending", q_idx.size(), 0);
    for (int i = 1; i < acc_n; i++)
      check($sformatf("b2b_period_%0d", i), q_cyc[i] - q_cyc[i-1], 10);
    repeat (2) @(posedge clk);

    // reset in the middle of a conversion of 0x9C
    @(negedge clk);
    start = 1'b1;
    din   = 8'h9C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy_s}, 32'd0);
    check("midrst_done", {31'd0, done_s}, 32'd0);
    check("midrst_bcd_s", {20'd0, bcd_s}, 32'd0);
    check("midrst_neg_s", {31'd0, neg_s}, 32'd0);
    check("midrst_bcd_u", {20'd0, bcd_u}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_s || busy_s) seen_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen_done}, 32'd0);
    run_conv(5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
